// File: rtl/cache_plru_pkg.sv
// Shared types and defaults for the tree pseudo-LRU replacement tracker.
package lc3b_types;

    // Default geometries: L1 is a small 2-way array, L2 keeps the legacy 4-way/64-set shape.
    localparam int unsigned L1_WAYS = 2;
    localparam int unsigned L1_SETS = 16;
    localparam int unsigned L2_WAYS = 4;
    localparam int unsigned L2_SETS = 64;

    localparam int unsigned PLRU_WAYW = $clog2(L2_WAYS);

    typedef logic [PLRU_WAYW-1:0] lc3b_plru_way;

    typedef enum logic {
        FLUSH_IDLE  = 1'b0,
        FLUSH_SWEEP = 1'b1
    } flush_state_e;

    // Index of the left (go_right=0) or right (go_right=1) child of a tree node.
    function automatic int unsigned plru_child(input int unsigned node, input logic go_right);
        return (2 * node) + 1 + 32'(go_right);
    endfunction

endpackage

// File: rtl/cache_plru_tree.sv
// Combinational tree-PLRU helpers: next state after touching a way, and the victim of a state.
// Node i lives at bit WAYS-2-i; leaves map left to right onto ways 0..WAYS-1.
module cache_plru_tree #(
    parameter int unsigned WAYS = 4
) (
    input  logic [WAYS-2:0]         state_i,
    input  logic [$clog2(WAYS)-1:0] access_way_i,
    output logic [WAYS-2:0]         next_state_c_o,
    output logic [$clog2(WAYS)-1:0] victim_c_o
);
    import lc3b_types::*;

    localparam int unsigned WAYW = $clog2(WAYS);

    // Point every node on the path to the touched way away from it.
    always_comb begin : tree_update
        next_state_c_o = state_i;
        for (int unsigned lvl = 0; lvl < WAYW; lvl++) begin
            for (int unsigned pos = 0; pos < (32'd1 << lvl); pos++) begin
                if (32'(access_way_i >> (WAYW - lvl)) == pos) begin
                    next_state_c_o[WAYS-2-((32'd1 << lvl) - 1 + pos)] = ~access_way_i[WAYW-1-lvl];
                end
            end
        end
    end

    // Follow node bits from the root (0 = left, 1 = right) down to a leaf.
    always_comb begin : tree_victim
        int unsigned node;
        logic        dir;
        node       = 0;
        dir        = 1'b0;
        victim_c_o = '0;
        for (int unsigned lvl = 0; lvl < WAYW; lvl++) begin
            dir = 1'b0;
            for (int unsigned n = 0; n < WAYS - 1; n++) begin
                if (n == node) begin
                    dir = state_i[WAYS-2-n];
                end
            end
            victim_c_o[WAYW-1-lvl] = dir;
            node = plru_child(node, dir);
        end
    end

endmodule

// File: rtl/cache_plru.sv
// Per-set tree pseudo-LRU tracker with registered victim output and a set-by-set flush sweep.
// Optional feature macro: PLRU_INVALID_FIRST_EN (prefer the lowest invalid way over the tree victim).
module cache_plru
    import lc3b_types::*;
#(
    parameter int unsigned WAYS = L2_WAYS,
    parameter int unsigned SETS = L2_SETS
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    lookup_valid,
    input  logic [$clog2(SETS)-1:0] lookup_index,
    output logic                    victim_valid,
    output logic [$clog2(WAYS)-1:0] victim_way,
    input  logic [WAYS-1:0]         way_valid,
    input  logic                    access_valid,
    input  logic [$clog2(SETS)-1:0] access_index,
    input  logic [$clog2(WAYS)-1:0] access_way,
    input  logic                    flush_req,
    output logic                    busy,
    output logic                    flush_done
);

    localparam int unsigned WAYW = $clog2(WAYS);
    localparam int unsigned IDXW = $clog2(SETS);
    localparam int unsigned TW   = WAYS - 1;

    logic [TW-1:0]   tree_q [SETS];
    flush_state_e    fsm_q, fsm_d;
    logic [IDXW-1:0] cnt_q, cnt_d;
    logic            victim_valid_q, victim_valid_d;
    logic [WAYW-1:0] victim_way_q, victim_way_d;
    logic            flush_done_q, flush_done_d;

    logic            idle_c;
    logic            lkp_en_c;
    logic            acc_en_c;
    logic [TW-1:0]   acc_state_c;
    logic [TW-1:0]   acc_next_c;
    logic [TW-1:0]   lkp_state_c;
    logic [WAYW-1:0] tree_victim_c;
    logic [WAYW-1:0] pick_victim_c;
    logic            tree_we_c;
    logic [IDXW-1:0] tree_waddr_c;
    logic [TW-1:0]   tree_wdata_c;

    logic [TW-1:0]   lkp_next_unused;
    logic [WAYW-1:0] acc_victim_unused;

    // Request qualification: the sweep owns the arrays; a flush request drops a same-cycle access.
    assign idle_c   = (fsm_q == FLUSH_IDLE);
    assign lkp_en_c = lookup_valid & idle_c;
    assign acc_en_c = access_valid & idle_c & ~flush_req;

    assign acc_state_c = tree_q[access_index];
    // Forward the in-flight update so a same-set lookup sees the post-access state.
    assign lkp_state_c = (acc_en_c && (access_index == lookup_index)) ? acc_next_c
                                                                      : tree_q[lookup_index];

    cache_plru_tree #(.WAYS(WAYS)) u_tree_update (
        .state_i        (acc_state_c),
        .access_way_i   (access_way),
        .next_state_c_o (acc_next_c),
        .victim_c_o     (acc_victim_unused)
    );

    cache_plru_tree #(.WAYS(WAYS)) u_tree_victim (
        .state_i        (lkp_state_c),
        .access_way_i   (access_way),
        .next_state_c_o (lkp_next_unused),
        .victim_c_o     (tree_victim_c)
    );

`ifdef PLRU_INVALID_FIRST_EN
    // Any invalid way beats the tree choice; the lowest-numbered one is taken.
    always_comb begin : invalid_first
        pick_victim_c = tree_victim_c;
        for (int i = int'(WAYS) - 1; i >= 0; i--) begin
            if (!way_valid[i]) begin
                pick_victim_c = WAYW'(i);
            end
        end
    end
`else
    logic unused_way_valid;
    assign unused_way_valid = ^way_valid;
    assign pick_victim_c    = tree_victim_c;
`endif

    // Flush FSM, tree write port selection and output next-state.
    always_comb begin : ctrl_next
        fsm_d          = fsm_q;
        cnt_d          = cnt_q;
        flush_done_d   = 1'b0;
        tree_we_c      = 1'b0;
        tree_waddr_c   = access_index;
        tree_wdata_c   = acc_next_c;
        victim_valid_d = lkp_en_c;
        victim_way_d   = lkp_en_c ? pick_victim_c : victim_way_q;
        case (fsm_q)
            FLUSH_IDLE: begin
                if (flush_req) begin
                    fsm_d = FLUSH_SWEEP;
                    cnt_d = '0;
                end else if (acc_en_c) begin
                    tree_we_c = 1'b1;
                end
            end
            FLUSH_SWEEP: begin
                tree_we_c    = 1'b1;
                tree_waddr_c = cnt_q;
                tree_wdata_c = '0;
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == IDXW'(SETS - 1)) begin
                    fsm_d        = FLUSH_IDLE;
                    cnt_d        = '0;
                    flush_done_d = 1'b1;
                end
            end
            default: begin
                fsm_d = FLUSH_IDLE;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk) begin : ctrl_regs
        if (!reset_n) begin
            fsm_q          <= FLUSH_IDLE;
            cnt_q          <= '0;
            victim_valid_q <= 1'b0;
            victim_way_q   <= '0;
            flush_done_q   <= 1'b0;
        end else begin
            fsm_q          <= fsm_d;
            cnt_q          <= cnt_d;
            victim_valid_q <= victim_valid_d;
            victim_way_q   <= victim_way_d;
            flush_done_q   <= flush_done_d;
        end
    end

    // Per-set tree state, single write port shared by accesses and the sweep.
    always_ff @(posedge clk) begin : tree_store
        if (!reset_n) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                tree_q[s] <= '0;
            end
        end else if (tree_we_c) begin
            tree_q[tree_waddr_c] <= tree_wdata_c;
        end
    end

    assign victim_valid = victim_valid_q;
    assign victim_way   = victim_way_q;
    assign flush_done   = flush_done_q;
    assign busy         = (fsm_q == FLUSH_SWEEP);

endmodule

// File: tb/tb_cache_plru.sv
// Directed bench for cache_plru at WAYS=4, SETS=64; expectations follow the PLRU_INVALID_FIRST_EN build.
module tb_cache_plru;

`ifdef PLRU_INVALID_FIRST_EN
    localparam bit INV_FIRST = 1'b1;
`else
    localparam bit INV_FIRST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       lookup_valid;
    logic [5:0] lookup_index;
    logic       victim_valid;
    logic [1:0] victim_way;
    logic [3:0] way_valid;
    logic       access_valid;
    logic [5:0] access_index;
    logic [1:0] access_way;
    logic       flush_req;
    logic       busy;
    logic       flush_done;

    int n_pass  = 0;
    int n_total = 0;

    cache_plru #(.WAYS(4), .SETS(64)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .lookup_valid (lookup_valid),
        .lookup_index (lookup_index),
        .victim_valid (victim_valid),
        .victim_way   (victim_way),
        .way_valid    (way_valid),
        .access_valid (access_valid),
        .access_index (access_index),
        .access_way   (access_way),
        .flush_req    (flush_req),
        .busy         (busy),
        .flush_done   (flush_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        n_total++; if (victim_valid !== 1'b0) $display("FAIL reset_vv: got %0b want 0", victim_valid); else n_pass++;
        n_total++; if (victim_way !== 2'd0) $display("FAIL reset_way: got %0d want 0", victim_way); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
        n_total++; if (flush_done !== 1'b0) $display("FAIL reset_done: got %0b want 0", flush_done); else n_pass++;
        reset_n = 1'b1;
        lookup_valid = 1'b1; lookup_index = 6'd5;
        tick();
        lookup_valid = 1'b0;
        n_total++; if (victim_valid !== 1'b1) $display("FAIL lkp5_vv: got %0b want 1", victim_valid); else n_pass++;
        n_total++; if (victim_way !== 2'd0) $display("FAIL lkp5_way: got %0d want 0", victim_way); else n_pass++;
        n_total++; if (busy !== 1'b0 || flush_done !== 1'b0) $display("FAIL lkp5_ctrl: got busy=%0b done=%0b want 0/0", busy, flush_done); else n_pass++;
        tick();
        n_total++; if (victim_valid !== 1'b0) $display("FAIL lkp5_pulse: got %0b want 0", victim_valid); else n_pass++;
    endtask

    task automatic test_access_single();
        access_valid = 1'b1; access_index = 6'd3; access_way = 2'd0;
        tick();
        access_valid = 1'b0;
        n_total++; if (dut.tree_q[3] !== 3'b110) $display("FAIL acc3_state: got %b want 110", dut.tree_q[3]); else n_pass++;
        lookup_valid = 1'b1; lookup_index = 6'd3;
        tick();
        lookup_valid = 1'b0;
        n_total++; if (victim_valid !== 1'b1 || victim_way !== 2'd2) $display("FAIL acc3_victim: got vv=%0b way=%0d want 1/2", victim_valid, victim_way); else n_pass++;
    endtask

    task automatic test_access_seq();
        logic [2:0] exp_seq [4];
        exp_seq = '{3'b110, 3'b100, 3'b001, 3'b000};
        for (int k = 0; k < 4; k++) begin
            access_valid = 1'b1; access_index = 6'd7; access_way = 2'(k);
            tick();
            n_total++; if (dut.tree_q[7] !== exp_seq[k]) $display("FAIL seq7_state%0d: got %b want %b", k, dut.tree_q[7], exp_seq[k]); else n_pass++;
        end
        access_valid = 1'b0;
        lookup_valid = 1'b1; lookup_index = 6'd7;
        tick();
        lookup_valid = 1'b0;
        n_total++; if (victim_valid !== 1'b1 || victim_way !== 2'd0) $display("FAIL seq7_victim: got vv=%0b way=%0d want 1/0", victim_valid, victim_way); else n_pass++;
    endtask

    task automatic test_forward();
        access_valid = 1'b1; access_index = 6'd9; access_way = 2'd0;
        lookup_valid = 1'b1; lookup_index = 6'd9;
        tick();
        access_valid = 1'b0; lookup_valid = 1'b0;
        n_total++; if (victim_valid !== 1'b1 || victim_way !== 2'd2) $display("FAIL fwd9_victim: got vv=%0b way=%0d want 1/2", victim_valid, victim_way); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [5:0] idx [3];
        logic [1:0] exp_way [3];
        idx     = '{6'd3, 6'd7, 6'd9};
        exp_way = '{2'd2, 2'd0, 2'd2};
        lookup_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            lookup_index = idx[k];
            tick();
            n_total++; if (victim_valid !== 1'b1 || victim_way !== exp_way[k]) $display("FAIL b2b%0d: got vv=%0b way=%0d want 1/%0d", k, victim_valid, victim_way, exp_way[k]); else n_pass++;
        end
        lookup_valid = 1'b0;
        tick();
        n_total++; if (victim_valid !== 1'b0 || victim_way !== 2'd2) $display("FAIL b2b_hold: got vv=%0b way=%0d want 0/2", victim_valid, victim_way); else n_pass++;
    endtask

    task automatic test_invalid_first();
        logic [1:0] exp_w;
        way_valid = 4'b1011; lookup_valid = 1'b1; lookup_index = 6'd20;
        tick();
        exp_w = INV_FIRST ? 2'd2 : 2'd0;
        n_total++; if (victim_way !== exp_w) $display("FAIL inv20_way: got %0d want %0d", victim_way, exp_w); else n_pass++;
        way_valid = 4'b0111; lookup_index = 6'd3;
        tick();
        exp_w = INV_FIRST ? 2'd3 : 2'd2;
        n_total++; if (victim_way !== exp_w) $display("FAIL inv3_way: got %0d want %0d", victim_way, exp_w); else n_pass++;
        way_valid = 4'b1111;
        tick();
        lookup_valid = 1'b0;
        n_total++; if (victim_way !== 2'd2) $display("FAIL allvalid3_way: got %0d want 2", victim_way); else n_pass++;
        n_total++; if (dut.tree_q[3] !== 3'b110) $display("FAIL inv3_state: got %b want 110", dut.tree_q[3]); else n_pass++;
    endtask

    task automatic test_flush();
        int busy_cycles;
        bit vv_seen;
        bit done_early;
        access_valid = 1'b1; access_index = 6'd10; access_way = 2'd0;
        tick();
        n_total++; if (dut.tree_q[10] !== 3'b110) $display("FAIL fl10_seed: got %b want 110", dut.tree_q[10]); else n_pass++;
        flush_req = 1'b1; access_index = 6'd11;
        tick();
        flush_req = 1'b0;
        lookup_valid = 1'b1; lookup_index = 6'd10;
        access_valid = 1'b1; access_index = 6'd10; access_way = 2'd3;
        busy_cycles = 0; vv_seen = 1'b0; done_early = 1'b0;
        while (busy === 1'b1 && busy_cycles < 200) begin
            busy_cycles++;
            if (victim_valid !== 1'b0) vv_seen = 1'b1;
            if (flush_done !== 1'b0) done_early = 1'b1;
            tick();
        end
        n_total++; if (busy_cycles != 64) $display("FAIL fl_busy_len: got %0d want 64", busy_cycles); else n_pass++;
        n_total++; if (vv_seen !== 1'b0) $display("FAIL fl_vv_during: got %0b want 0", vv_seen); else n_pass++;
        n_total++; if (done_early !== 1'b0) $display("FAIL fl_done_early: got %0b want 0", done_early); else n_pass++;
        n_total++; if (flush_done !== 1'b1 || victim_valid !== 1'b0) $display("FAIL fl_done: got done=%0b vv=%0b want 1/0", flush_done, victim_valid); else n_pass++;
        lookup_valid = 1'b0; access_valid = 1'b0;
        tick();
        n_total++; if (flush_done !== 1'b0) $display("FAIL fl_done_pulse: got %0b want 0", flush_done); else n_pass++;
        n_total++; if (dut.tree_q[10] !== 3'b000) $display("FAIL fl10_state: got %b want 000", dut.tree_q[10]); else n_pass++;
        lookup_valid = 1'b1; lookup_index = 6'd10;
        tick();
        lookup_valid = 1'b0;
        n_total++; if (victim_valid !== 1'b1 || victim_way !== 2'd0) $display("FAIL fl10_victim: got vv=%0b way=%0d want 1/0", victim_valid, victim_way); else n_pass++;
    endtask

    task automatic test_reset_mid_flush();
        bit done_seen;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        repeat (19) tick();
        n_total++; if (busy !== 1'b1) $display("FAIL rmf_busy: got %0b want 1", busy); else n_pass++;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        n_total++; if (busy !== 1'b0 || flush_done !== 1'b0) $display("FAIL rmf_abort: got busy=%0b done=%0b want 0/0", busy, flush_done); else n_pass++;
        done_seen = 1'b0;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (flush_done !== 1'b0 || busy !== 1'b0) done_seen = 1'b1;
        end
        n_total++; if (done_seen !== 1'b0) $display("FAIL rmf_no_done: got %0b want 0", done_seen); else n_pass++;
    endtask

    initial begin
        reset_n = 1'b0; lookup_valid = 1'b0; lookup_index = '0; way_valid = 4'b1111;
        access_valid = 1'b0; access_index = '0; access_way = '0; flush_req = 1'b0;
        #1;
        test_reset();
        test_access_single();
        test_access_seq();
        test_forward();
        test_back_to_back();
        test_invalid_first();
        test_flush();
        test_reset_mid_flush();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cache_plru.md
# cache_plru

Parametrised tree pseudo-LRU replacement tracker for set-associative caches (L1/L2), generalising the fixed 4-way, 3-bit L2 LRU to any power-of-two associativity and set count. It holds per-set tree state in resettable flops and returns a registered victim way per lookup. It supports a multi-cycle flush sweep and can optionally prefer invalid ways. It sits beside the tag/data arrays and is driven by the cache controller.

## Interface
- WAYS, 4, associativity; power of two, 2..16; WAYW = $clog2(WAYS)
- SETS, 64, number of sets; power of two; IDXW = $clog2(SETS)
- clk  in  1  rising-edge clock; the only clock
- reset_n  in  1  synchronous, active-low reset
- lookup_valid  in  1  victim query for lookup_index
- lookup_index  in  IDXW  set to query
- victim_valid  out  1  victim_way valid, one cycle after an accepted lookup
- victim_way  out  WAYW  way to replace
- way_valid  in  WAYS  valid bits of the queried set, sampled with lookup_valid
- access_valid  in  1  hit or fill touch; marks access_way MRU in access_index
- access_index  in  IDXW  set touched
- access_way  in  WAYW  way touched
- flush_req  in  1  single-cycle request to clear all set states
- busy  out  1  flush sweep in progress; lookups and accesses ignored
- flush_done  out  1  one-cycle pulse when the sweep completes

## Operation
- Per-set state: WAYS-1 tree bits. Node i has children 2i+1 and 2i+2; leaves map left to right onto ways 0..WAYS-1.
- Storage bit order: node i is stored at bit WAYS-2-i. For WAYS=4 this is {root, node(0/1), node(2/3)}, bit-compatible with the legacy 3-bit encoding.
- Victim walk: start at the root. Node bit 0 goes left and 1 goes right; the reached leaf is the victim.
- Access update: for every node on the path to access_way, write 1 if access_way is in the left subtree and 0 if it is in the right. Nodes off the path are unchanged.
- Forwarding: if lookup and access target the same index in the same cycle, the victim is computed from the post-update state.
- Flush FSM, states IDLE and FLUSH:
  - IDLE -> FLUSH on flush_req. The counter starts at 0.
  - Each FLUSH cycle clears state[counter] to 0 and increments the counter.
  - After clearing SETS-1 the FSM returns to IDLE, with flush_done high for exactly one cycle on the next cycle.
  - busy = (state == FLUSH).
- While busy: lookup_valid and access_valid are ignored, victim_valid stays 0, and flush_req is ignored.
- flush_req together with access_valid in IDLE: the flush wins and the access is dropped.
- Reset values: all tree state 0, FSM IDLE, counter 0, victim_valid 0, victim_way 0, busy 0, flush_done 0. Reset mid-flush aborts to IDLE with no flush_done pulse.

## Timing
- Lookup accepted at edge N produces victim_valid/victim_way registered at edge N+1.
- victim_valid is high only for one cycle per lookup. victim_way holds its last value when victim_valid is low.
- An access sampled at edge N updates state at edge N; lookups sampled at edge N+1 or later see the update.
- Back-to-back lookups are allowed every cycle, giving throughput of one lookup per cycle.
- A flush occupies SETS cycles with busy high, followed by flush_done.

## Configuration
- PLRU_INVALID_FIRST_EN defined: if way_valid has any zero bit, victim_way is the lowest-numbered invalid way. Otherwise the tree victim is returned. Tree state is not modified by the lookup.
- PLRU_INVALID_FIRST_EN undefined: way_valid port is present but ignored; the victim always comes from the tree.

## Structure
- lc3b_types holds:
  - lc3b_plru_way typedef (WAYW bits)
  - WAYS/SETS defaults for L1 and L2
  - tree-node child-index helper function
- Sub-module cache_plru_tree: a combinational function pair mapping (state, access_way) to next state and (state) to victim, parametrised by WAYS. It is instantiated once for update and once for the forwarded victim.
- The top holds the state flop array, the flush FSM/counter and the output registers.

## Test plan
- Reset, then lookup index 5 -> next cycle victim_valid=1, victim_way=0; busy=0, flush_done=0.
- WAYS=4: access way 0 at index 3, then lookup index 3 -> victim_way=2, stored state 3'b110.
- Access ways 0,1,2,3 in order at index 7 -> states 110, 100, 001, 000; lookup -> victim_way=0.
- Same cycle: access way 0 at index 9 and lookup index 9 from reset state -> victim_way=2 (forwarded).
- Set index 10 to 110, pulse flush_req, issue access and lookup during the sweep -> busy high for 64 cycles, then one-cycle flush_done, then victim_valid stays 0 during the sweep. A subsequent lookup at index 10 returns way 0. Assert reset_n low at sweep cycle 20 -> IDLE, no flush_done pulse.
- Index state 000, way_valid=4'b1011: with PLRU_INVALID_FIRST_EN -> victim_way=2; without the macro -> victim_way=0.
